write_txn_tracker: RTL and testbench

WRITE_TXN_TRACKER -- requirements
Module: write_txn_tracker

---
 rtl/write_txn_tracker.sv | 245 ++++++++++++++++++++++++
 tb/tb_write_txn_tracker.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_txn_tracker.sv
// Tracks up to NumSlots outstanding AXI write transactions observed on AW/W/B,
// enforcing per-phase cycle budgets and flagging protocol violations.
module write_txn_tracker #(
    parameter int NumSlots = 4,
    parameter int IdWidth  = 6,
    parameter int CntWidth = 10
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        aw_valid_i,
    input  logic                        aw_ready_i,
    input  logic [IdWidth-1:0]          aw_id_i,
    input  logic                        w_valid_i,
    input  logic                        w_ready_i,
    input  logic                        w_last_i,
    input  logic                        b_valid_i,
    input  logic                        b_ready_i,
    input  logic [IdWidth-1:0]          b_id_i,
    input  logic [CntWidth-1:0]         budget_w_i,
    input  logic [CntWidth-1:0]         budget_b_i,
    input  logic                        clr_i,
    output logic                        aw_stall_o,
    output logic                        timeout_o,
    output logic [IdWidth-1:0]          timeout_id_o,
    output logic                        proto_err_o,
    output logic                        busy_o,
    output logic [$clog2(NumSlots):0]   txn_cnt_o
);

    localparam int SlotW = $clog2(NumSlots);
    localparam int TxnW  = SlotW + 1;

    typedef enum logic [1:0] {
        WRITE_IDLE     = 2'd0,
        WRITE_ADDRESS  = 2'd1,
        WRITE_DATA     = 2'd2,
        WRITE_RESPONSE = 2'd3
    } write_state_t;

    write_state_t          state_q [NumSlots];
    write_state_t          state_d [NumSlots];
    logic [IdWidth-1:0]    id_q    [NumSlots];
    logic [IdWidth-1:0]    id_d    [NumSlots];
    logic [CntWidth-1:0]   cnt_q   [NumSlots];
    logic [CntWidth-1:0]   cnt_d   [NumSlots];
    logic                  exp_q   [NumSlots];
    logic                  exp_d   [NumSlots];
    logic [SlotW-1:0]      fifo_q  [NumSlots];
    logic [SlotW-1:0]      fifo_d  [NumSlots];
    logic [SlotW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [SlotW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [SlotW:0]        q_cnt_q, q_cnt_d;
    logic                  timeout_q, timeout_d;
    logic [IdWidth-1:0]    timeout_id_q, timeout_id_d;
    logic                  proto_err_q, proto_err_d;
    logic                  busy_q, busy_d;
    logic [TxnW-1:0]       txn_cnt_q, txn_cnt_d;

    logic                  aw_hs_s, w_hs_s, b_hs_s;
    logic                  all_busy_s, id_hit_s, aw_stall_s;
    logic                  free_found_s, b_found_s;
    logic [SlotW-1:0]      free_idx_s, b_idx_s, head_s;
    logic                  q_empty_s, aw_take_s, w_take_s, b_take_s;
    logic                  tmo_found_s;
    logic [IdWidth-1:0]    tmo_id_s;
    logic                  proto_ev_s;

    assign aw_hs_s    = aw_valid_i & aw_ready_i;
    assign w_hs_s     = w_valid_i & w_ready_i;
    assign b_hs_s     = b_valid_i & b_ready_i;
    assign aw_stall_s = all_busy_s | id_hit_s;
    assign q_empty_s  = (q_cnt_q == '0);
    assign head_s     = fifo_q[rd_ptr_q];
    assign aw_take_s  = aw_hs_s & ~aw_stall_s;
    assign w_take_s   = w_hs_s & ~q_empty_s;
    assign b_take_s   = b_hs_s & b_found_s;
    assign proto_ev_s = (aw_hs_s & aw_stall_s) | (w_hs_s & q_empty_s) | (b_hs_s & ~b_found_s);

    // Scan registered slot state: free slot, duplicate AW ID, B match.
    always_comb begin
        all_busy_s   = 1'b1;
        id_hit_s     = 1'b0;
        free_found_s = 1'b0;
        free_idx_s   = '0;
        b_found_s    = 1'b0;
        b_idx_s      = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (state_q[i] == WRITE_IDLE) begin
                all_busy_s = 1'b0;
                if (!free_found_s) begin
                    free_found_s = 1'b1;
                    free_idx_s   = SlotW'(i);
                end else begin
                    free_idx_s   = free_idx_s;
                end
            end else begin
                id_hit_s = id_hit_s | (id_q[i] == aw_id_i);
            end
            if ((state_q[i] == WRITE_RESPONSE) && (id_q[i] == b_id_i) && !b_found_s) begin
                b_found_s = 1'b1;
                b_idx_s   = SlotW'(i);
            end else begin
                b_idx_s   = b_idx_s;
            end
        end
    end

    // Per-slot next state, budget counters, timeout detection and W queue.
    always_comb begin
        fifo_d      = fifo_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        q_cnt_d     = q_cnt_q;
        tmo_found_s = 1'b0;
        tmo_id_s    = '0;
        for (int i = 0; i < NumSlots; i++) begin
            logic trans_v;
            state_d[i] = state_q[i];
            id_d[i]    = id_q[i];
            cnt_d[i]   = cnt_q[i];
            exp_d[i]   = exp_q[i];
            trans_v    = 1'b1;
            if (aw_take_s && (free_idx_s == SlotW'(i))) begin
                state_d[i] = WRITE_ADDRESS;
                id_d[i]    = aw_id_i;
                cnt_d[i]   = budget_w_i;
            end else if (w_take_s && (head_s == SlotW'(i)) &&
                         (w_last_i || (state_q[i] == WRITE_ADDRESS))) begin
                if (w_last_i) begin
                    state_d[i] = WRITE_RESPONSE;
                    cnt_d[i]   = budget_b_i;
                end else begin
                    state_d[i] = WRITE_DATA;
                    cnt_d[i]   = (cnt_q[i] != '0) ? cnt_q[i] - CntWidth'(1) : cnt_q[i];
                end
            end else if (b_take_s && (b_idx_s == SlotW'(i))) begin
                state_d[i] = WRITE_IDLE;
                cnt_d[i]   = '0;
            end else begin
                trans_v    = 1'b0;
            end

            // Each phase may time out only once; a fresh phase re-arms it.
            if (trans_v) begin
                exp_d[i] = 1'b0;
            end else if (state_q[i] != WRITE_IDLE) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CntWidth'(1);
                end else if (!exp_q[i]) begin
                    exp_d[i] = 1'b1;
                    if (!tmo_found_s) begin
                        tmo_found_s = 1'b1;
                        tmo_id_s    = id_q[i];
                    end else begin
                        tmo_id_s    = tmo_id_s;
                    end
                end else begin
                    exp_d[i] = exp_q[i];
                end
            end else begin
                exp_d[i] = exp_q[i];
            end
        end

        if (aw_take_s) begin
            fifo_d[wr_ptr_q] = free_idx_s;
            wr_ptr_d         = wr_ptr_q + SlotW'(1);
        end else begin
            wr_ptr_d         = wr_ptr_q;
        end
        if (w_take_s && w_last_i) begin
            rd_ptr_d = rd_ptr_q + SlotW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        q_cnt_d = q_cnt_q + (SlotW+1)'(aw_take_s) - (SlotW+1)'(w_take_s & w_last_i);
    end

    // Sticky flags and occupancy; a new event outranks a same-cycle clear.
    always_comb begin
        proto_err_d = proto_ev_s | (proto_err_q & ~clr_i);
        timeout_d   = tmo_found_s | (timeout_q & ~clr_i);
        if (tmo_found_s && !(timeout_q && !clr_i)) begin
            timeout_id_d = tmo_id_s;
        end else if (clr_i) begin
            timeout_id_d = '0;
        end else begin
            timeout_id_d = timeout_id_q;
        end
        txn_cnt_d = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (state_d[i] != WRITE_IDLE) begin
                txn_cnt_d = txn_cnt_d + TxnW'(1);
            end else begin
                txn_cnt_d = txn_cnt_d;
            end
        end
        busy_d = (txn_cnt_d != '0);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumSlots; i++) begin
                state_q[i] <= WRITE_IDLE;
                id_q[i]    <= '0;
                cnt_q[i]   <= '0;
                exp_q[i]   <= 1'b0;
                fifo_q[i]  <= '0;
            end
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            q_cnt_q      <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
            proto_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            txn_cnt_q    <= '0;
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                state_q[i] <= state_d[i];
                id_q[i]    <= id_d[i];
                cnt_q[i]   <= cnt_d[i];
                exp_q[i]   <= exp_d[i];
                fifo_q[i]  <= fifo_d[i];
            end
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            q_cnt_q      <= q_cnt_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
            proto_err_q  <= proto_err_d;
            busy_q       <= busy_d;
            txn_cnt_q    <= txn_cnt_d;
        end
    end

    assign aw_stall_o   = aw_stall_s;
    assign timeout_o    = timeout_q;
    assign timeout_id_o = timeout_id_q;
    assign proto_err_o  = proto_err_q;
    assign busy_o       = busy_q;
    assign txn_cnt_o    = txn_cnt_q;

endmodule

// File: tb/tb_write_txn_tracker.sv
// Directed self-checking bench for write_txn_tracker (default parameters).
module tb_write_txn_tracker;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        aw_valid_i, aw_ready_i, w_valid_i, w_ready_i, w_last_i;
    logic        b_valid_i, b_ready_i, clr_i;
    logic [5:0]  aw_id_i, b_id_i;
    logic [9:0]  budget_w_i, budget_b_i;
    logic        aw_stall_o, timeout_o, proto_err_o, busy_o;
    logic [5:0]  timeout_id_o;
    logic [2:0]  txn_cnt_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    write_txn_tracker #(.NumSlots(4), .IdWidth(6), .CntWidth(10)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .aw_valid_i(aw_valid_i), .aw_ready_i(aw_ready_i), .aw_id_i(aw_id_i),
        .w_valid_i(w_valid_i), .w_ready_i(w_ready_i), .w_last_i(w_last_i),
        .b_valid_i(b_valid_i), .b_ready_i(b_ready_i), .b_id_i(b_id_i),
        .budget_w_i(budget_w_i), .budget_b_i(budget_b_i), .clr_i(clr_i),
        .aw_stall_o(aw_stall_o), .timeout_o(timeout_o), .timeout_id_o(timeout_id_o),
        .proto_err_o(proto_err_o), .busy_o(busy_o), .txn_cnt_o(txn_cnt_o)
    );

    task automatic idle_inputs();
        aw_valid_i = 1'b0; aw_ready_i = 1'b0;
        w_valid_i  = 1'b0; w_ready_i  = 1'b0; w_last_i = 1'b0;
        b_valid_i  = 1'b0; b_ready_i  = 1'b0;
        clr_i      = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
        idle_inputs();
    endtask

    task automatic drive_aw(input logic [5:0] id);
        aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_id_i = id;
    endtask

    task automatic drive_w(input logic last);
        w_valid_i = 1'b1; w_ready_i = 1'b1; w_last_i = last;
    endtask

    task automatic drive_b(input logic [5:0] id);
        b_valid_i = 1'b1; b_ready_i = 1'b1; b_id_i = id;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        aw_id_i = 6'd0; b_id_i = 6'd0;
        budget_w_i = 10'd20; budget_b_i = 10'd20;
        #12;
        checks++;
        if ({aw_stall_o, timeout_o, proto_err_o, busy_o} !== 4'b0000 ||
            timeout_id_o !== 6'd0 || txn_cnt_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b to=%b pe=%b busy=%b id=%0d cnt=%0d want all 0",
                     aw_stall_o, timeout_o, proto_err_o, busy_o, timeout_id_o, txn_cnt_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        apply_reset();
        budget_w_i = 10'd20; budget_b_i = 10'd20;
        drive_aw(6'd3); cyc();
        checks++;
        if (dut.state_q[0] !== 2'd1 || txn_cnt_o !== 3'd1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_aw: got state=%0d cnt=%0d busy=%b want 1 1 1", dut.state_q[0], txn_cnt_o, busy_o);
        end
        drive_w(1'b0); cyc();
        checks++;
        if (dut.state_q[0] !== 2'd2) begin
            errors++;
            $display("FAIL basic_w1: got state=%0d want 2", dut.state_q[0]);
        end
        drive_w(1'b1); cyc();
        checks++;
        if (dut.state_q[0] !== 2'd3 || txn_cnt_o !== 3'd1) begin
            errors++;
            $display("FAIL basic_wlast: got state=%0d cnt=%0d want 3 1", dut.state_q[0], txn_cnt_o);
        end
        drive_b(6'd3); cyc();
        checks++;
        if (dut.state_q[0] !== 2'd0 || txn_cnt_o !== 3'd0 || busy_o !== 1'b0 ||
            proto_err_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_b: got state=%0d cnt=%0d busy=%b pe=%b to=%b want 0 0 0 0 0",
                     dut.state_q[0], txn_cnt_o, busy_o, proto_err_o, timeout_o);
        end
    endtask

    task automatic test_full();
        apply_reset();
        budget_w_i = 10'd40; budget_b_i = 10'd40;
        for (int k = 1; k <= 4; k++) begin
            drive_aw(6'(k)); cyc();
        end
        drive_aw(6'd5); #1;
        checks++;
        if (aw_stall_o !== 1'b1 || txn_cnt_o !== 3'd4) begin
            errors++;
            $display("FAIL full_stall: got stall=%b cnt=%0d want 1 4", aw_stall_o, txn_cnt_o);
        end
        cyc();
        checks++;
        if (proto_err_o !== 1'b1 || txn_cnt_o !== 3'd4) begin
            errors++;
            $display("FAIL full_aw_err: got pe=%b cnt=%0d want 1 4", proto_err_o, txn_cnt_o);
        end
        drive_w(1'b1); cyc();
        drive_b(6'd1); cyc();
        drive_aw(6'd5); #1;
        checks++;
        if (aw_stall_o !== 1'b0 || txn_cnt_o !== 3'd3) begin
            errors++;
            $display("FAIL full_freed: got stall=%b cnt=%0d want 0 3", aw_stall_o, txn_cnt_o);
        end
        cyc();
        checks++;
        if (txn_cnt_o !== 3'd4 || dut.id_q[0] !== 6'd5 || dut.state_q[0] !== 2'd1) begin
            errors++;
            $display("FAIL full_realloc: got cnt=%0d id0=%0d st0=%0d want 4 5 1", txn_cnt_o, dut.id_q[0], dut.state_q[0]);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        budget_w_i = 10'd5; budget_b_i = 10'd20;
        drive_aw(6'd7); cyc();
        for (int k = 0; k < 5; k++) cyc();
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got to=%b after 5 edges want 0", timeout_o);
        end
        cyc();
        checks++;
        if (timeout_o !== 1'b1 || timeout_id_o !== 6'd7) begin
            errors++;
            $display("FAIL timeout_6th: got to=%b id=%0d want 1 7", timeout_o, timeout_id_o);
        end
        clr_i = 1'b1; cyc();
        checks++;
        if (timeout_o !== 1'b0 || timeout_id_o !== 6'd0 || proto_err_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clr: got to=%b id=%0d pe=%b want 0 0 0", timeout_o, timeout_id_o, proto_err_o);
        end
        // Zero budget expires on the edge right after the phase starts.
        apply_reset();
        budget_w_i = 10'd0;
        drive_aw(6'h2A); cyc();
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_budget_load: got to=%b want 0", timeout_o);
        end
        cyc();
        checks++;
        if (timeout_o !== 1'b1 || timeout_id_o !== 6'h2A) begin
            errors++;
            $display("FAIL zero_budget: got to=%b id=%0d want 1 42", timeout_o, timeout_id_o);
        end
    endtask

    task automatic test_dup_id();
        apply_reset();
        budget_w_i = 10'd40; budget_b_i = 10'd40;
        drive_aw(6'd9); cyc();
        aw_id_i = 6'd9; #1;
        checks++;
        if (aw_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL dup_stall: got stall=%b want 1", aw_stall_o);
        end
        aw_id_i = 6'd10; #1;
        checks++;
        if (aw_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL dup_other_id: got stall=%b want 0", aw_stall_o);
        end
        drive_b(6'h3F); cyc();
        checks++;
        if (proto_err_o !== 1'b1 || txn_cnt_o !== 3'd1) begin
            errors++;
            $display("FAIL b_unmatched: got pe=%b cnt=%0d want 1 1", proto_err_o, txn_cnt_o);
        end
    endtask

    task automatic test_same_cycle_free();
        apply_reset();
        budget_w_i = 10'd40; budget_b_i = 10'd40;
        for (int k = 1; k <= 4; k++) begin
            drive_aw(6'(k)); cyc();
        end
        drive_w(1'b1); cyc();
        drive_b(6'd1); drive_aw(6'd5); #1;
        checks++;
        if (aw_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_stall: got stall=%b want 1", aw_stall_o);
        end
        cyc();
        checks++;
        if (proto_err_o !== 1'b1 || txn_cnt_o !== 3'd3 || dut.state_q[0] !== 2'd0) begin
            errors++;
            $display("FAIL same_cycle_free: got pe=%b cnt=%0d st0=%0d want 1 3 0", proto_err_o, txn_cnt_o, dut.state_q[0]);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        budget_w_i = 10'd40; budget_b_i = 10'd40;
        drive_aw(6'd6); drive_w(1'b1); cyc();
        checks++;
        if (proto_err_o !== 1'b1 || txn_cnt_o !== 3'd1 || dut.state_q[0] !== 2'd1) begin
            errors++;
            $display("FAIL aw_w_empty: got pe=%b cnt=%0d st0=%0d want 1 1 1", proto_err_o, txn_cnt_o, dut.state_q[0]);
        end
        clr_i = 1'b1; drive_aw(6'd8); drive_w(1'b1); cyc();
        checks++;
        if (proto_err_o !== 1'b0 || txn_cnt_o !== 3'd2 || dut.state_q[0] !== 2'd3 || dut.state_q[1] !== 2'd1) begin
            errors++;
            $display("FAIL aw_w_pair: got pe=%b cnt=%0d st0=%0d st1=%0d want 0 2 3 1",
                     proto_err_o, txn_cnt_o, dut.state_q[0], dut.state_q[1]);
        end
        drive_aw(6'd10); drive_w(1'b1); drive_b(6'd6); cyc();
        checks++;
        if (proto_err_o !== 1'b0 || txn_cnt_o !== 3'd2 || dut.state_q[0] !== 2'd0 ||
            dut.state_q[1] !== 2'd3 || dut.state_q[2] !== 2'd1) begin
            errors++;
            $display("FAIL aw_w_b_triple: got pe=%b cnt=%0d st=%0d/%0d/%0d want 0 2 0/3/1",
                     proto_err_o, txn_cnt_o, dut.state_q[0], dut.state_q[1], dut.state_q[2]);
        end
        clr_i = 1'b1; drive_b(6'h3F); cyc();
        checks++;
        if (proto_err_o !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_event: got pe=%b want 1", proto_err_o);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        budget_w_i = 10'd40; budget_b_i = 10'd40;
        drive_aw(6'd3); cyc();
        drive_w(1'b0); cyc();
        drive_b(6'h3F); cyc();
        aw_id_i = 6'd3; #1;
        checks++;
        if (dut.state_q[0] !== 2'd2 || aw_stall_o !== 1'b1 || proto_err_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got st0=%0d stall=%b pe=%b busy=%b want 2 1 1 1",
                     dut.state_q[0], aw_stall_o, proto_err_o, busy_o);
        end
        #1 rst_ni = 1'b0;
        #1;
        checks++;
        if ({aw_stall_o, timeout_o, proto_err_o, busy_o} !== 4'b0000 ||
            timeout_id_o !== 6'd0 || txn_cnt_o !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: got stall=%b to=%b pe=%b busy=%b id=%0d cnt=%0d want all 0",
                     aw_stall_o, timeout_o, proto_err_o, busy_o, timeout_id_o, txn_cnt_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_timeout();
        test_dup_id();
        test_same_cycle_free();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
